// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and arbiter state encoding for the register file access path
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  typedef enum logic [1:0] {INIT, IDLE, DBG, GAP} state_t;
endpackage

// File: rtl/regfile_arb.sv
// regfile_arb: zero-sweeps the register file after reset, then arbitrates core writeback and debug access
module regfile_arb
  import regfile_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            core_we_i,
  input  logic [AW-1:0]   core_rd_i,
  input  logic [XLEN-1:0] core_data_i,
  input  logic [AW-1:0]   core_rs2_i,
  output logic            core_stall_o,
  input  logic            dbg_req_i,
  input  logic            dbg_wr_i,
  input  logic [AW-1:0]   dbg_addr_i,
  input  logic [XLEN-1:0] dbg_wdata_i,
  output logic            dbg_ready_o,
  output logic            dbg_rvalid_o,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic            rf_we_o,
  output logic [AW-1:0]   rf_rd_o,
  output logic [XLEN-1:0] rf_data_o,
  output logic [AW-1:0]   rf_rs2_o,
  input  logic [XLEN-1:0] rf_rs2_data_i
);
  state_t          state;
  logic [AW-1:0]   cnt;
  logic            cap_wr;
  logic [AW-1:0]   cap_addr;
  logic [XLEN-1:0] cap_wdata;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= INIT;
      cnt          <= '0;
      cap_wr       <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      dbg_rvalid_o <= 1'b0;
      dbg_rdata_o  <= '0;
    end else begin
      dbg_rvalid_o <= state == DBG;
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(NREG - 1)) state <= IDLE;
        end
        IDLE: if (dbg_req_i && dbg_ready_o) begin
          cap_wr    <= dbg_wr_i;
          cap_addr  <= dbg_addr_i;
          cap_wdata <= dbg_wdata_i;
          state     <= DBG;
        end
        DBG: begin
          if (!cap_wr) dbg_rdata_o <= rf_rs2_data_i;
          state <= GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // IDLE and GAP both give the core the ports; only INIT and DBG take them away
  always_comb begin
    core_stall_o = rst_i || state == INIT || state == DBG;
    dbg_ready_o  = !rst_i && state == IDLE;
    rf_we_o      = rst_i ? 1'b0 :
                   state == INIT ? 1'b1 :
                   state == DBG  ? cap_wr && cap_addr != '0 :
                   core_we_i && core_rd_i != '0;
    rf_rd_o      = state == INIT ? cnt : state == DBG ? cap_addr : core_rd_i;
    rf_data_o    = state == INIT ? '0 : state == DBG ? cap_wdata : core_data_i;
    rf_rs2_o     = state == DBG ? cap_addr : core_rs2_i;
  end
endmodule

// File: tb/tb_regfile_arb.sv
// tb_regfile_arb: directed scenario checks of regfile_arb against a behavioural register file
module tb_regfile_arb;
  import regfile_pkg::*;
  logic clk = 0, rst = 0;
  logic core_we = 0, dbg_req = 0, dbg_wr = 0;
  logic [AW-1:0] core_rd = '0, core_rs2 = '0, dbg_addr = '0;
  logic [XLEN-1:0] core_data = '0, dbg_wdata = '0;
  logic stall, ready, rvalid, rf_we;
  logic [XLEN-1:0] rdata, rf_data, rs2_data;
  logic [AW-1:0] rf_rd, rf_rs2;
  logic [XLEN-1:0] mem [NREG];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (rf_we) mem[rf_rd] <= rf_data;
  assign rs2_data = mem[rf_rs2];

  regfile_arb dut (
    .clk_i(clk), .rst_i(rst), .core_we_i(core_we), .core_rd_i(core_rd), .core_data_i(core_data),
    .core_rs2_i(core_rs2), .core_stall_o(stall), .dbg_req_i(dbg_req), .dbg_wr_i(dbg_wr),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata), .dbg_ready_o(ready), .dbg_rvalid_o(rvalid),
    .dbg_rdata_o(rdata), .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_data_o(rf_data),
    .rf_rs2_o(rf_rs2), .rf_rs2_data_i(rs2_data)
  );

  task automatic test_reset;
    int bad;
    @(negedge clk); rst = 1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall got %b exp 1", stall); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", rf_we); end
    @(negedge clk); rst = 0; #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (rf_we !== 1'b1 || rf_rd !== AW'(i) || rf_data !== 32'h0 || stall !== 1'b1 || ready !== 1'b0) begin
        bad++;
        $display("FAIL sweep_cycle%0d got we=%b rd=%0d data=%h stall=%b ready=%b exp 1 %0d 0 1 0", i, rf_we, rf_rd, rf_data, stall, ready, i);
      end
      @(negedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL sweep_bad_cycles got %0d exp 0", bad); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL cycle33_ready got %b exp 1", ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cycle33_stall got %b exp 0", stall); end
    checks++; if (mem[31] !== 32'h0) begin errors++; $display("FAIL sweep_x31 got %h exp 0", mem[31]); end
  endtask

  task automatic test_core_write;
    @(negedge clk); core_we = 1; core_rd = 5; core_data = 32'hDEADBEEF; core_rs2 = 12; #1;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL core_we5 got %b exp 1", rf_we); end
    checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL core_rd5 got %0d exp 5", rf_rd); end
    checks++; if (rf_data !== 32'hDEADBEEF) begin errors++; $display("FAIL core_data5 got %h exp deadbeef", rf_data); end
    checks++; if (rf_rs2 !== 5'd12) begin errors++; $display("FAIL core_rs2 got %0d exp 12", rf_rs2); end
    @(negedge clk); core_rd = 0; core_data = 32'h1234; #1;
    checks++; if (mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL mem_x5 got %h exp deadbeef", mem[5]); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL core_we_x0 got %b exp 0", rf_we); end
    @(negedge clk); core_we = 0;
  endtask

  task automatic test_dbg_write_read;
    @(negedge clk); dbg_req = 1; dbg_wr = 1; dbg_addr = 7; dbg_wdata = 32'hCAFEF00D; #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL dw_accept_ready got %b exp 1", ready); end
    @(negedge clk); dbg_req = 0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL dw_dbg_stall got %b exp 1", stall); end
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'hCAFEF00D) begin errors++; $display("FAIL dw_port got we=%b rd=%0d data=%h exp 1 7 cafef00d", rf_we, rf_rd, rf_data); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL dw_dbg_ready got %b exp 0", ready); end
    @(negedge clk); #1;
    checks++; if (rvalid !== 1'b1 || stall !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL dw_gap got rvalid=%b stall=%b ready=%b exp 1 0 0", rvalid, stall, ready); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL dw_rdata_held got %h exp 0", rdata); end
    @(negedge clk); dbg_req = 1; dbg_wr = 0; dbg_addr = 7; #1;
    checks++; if (ready !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL dr_accept got ready=%b rvalid=%b exp 1 0", ready, rvalid); end
    @(negedge clk); dbg_req = 0; #1;
    checks++; if (rf_rs2 !== 5'd7 || rf_we !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL dr_dbg got rs2=%0d we=%b stall=%b exp 7 0 1", rf_rs2, rf_we, stall); end
    @(negedge clk); #1;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL dr_done got rvalid=%b rdata=%h exp 1 cafef00d", rvalid, rdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int acc, rv, st, pat;
    acc = 0; rv = 0; st = 0; pat = 0;
    @(negedge clk); dbg_req = 1; dbg_wr = 0; dbg_addr = 5;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (ready) acc++;
      if (rvalid) rv++;
      if (stall) st++;
      if (stall !== (i % 3 == 1)) pat++;
      @(negedge clk);
    end
    dbg_req = 0;
    checks++; if (acc !== 3) begin errors++; $display("FAIL b2b_accepts got %0d exp 3", acc); end
    checks++; if (rv !== 3) begin errors++; $display("FAIL b2b_rvalids got %0d exp 3", rv); end
    checks++; if (st !== 3 || pat !== 0) begin errors++; $display("FAIL b2b_stall got count=%0d misplaced=%0d exp 3 0", st, pat); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata got %h exp deadbeef", rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_dbg;
    int n, rv;
    @(negedge clk); dbg_req = 1; dbg_wr = 1; dbg_addr = 9; dbg_wdata = 32'h99; #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rm_accept got %b exp 1", ready); end
    @(negedge clk); dbg_req = 0; rst = 1; #1;
    checks++; if (rf_we !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL rm_forced got we=%b stall=%b exp 0 1", rf_we, stall); end
    @(negedge clk); rst = 0; #1;
    checks++; if (mem[9] !== 32'h0) begin errors++; $display("FAIL rm_x9 got %h exp 0", mem[9]); end
    n = 0; rv = 0;
    for (int i = 0; i < 40 && !ready; i++) begin
      if (rf_we && rf_rd === AW'(n)) n++;
      if (rvalid) rv++;
      @(negedge clk); #1;
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL rm_sweep_len got %0d exp 32", n); end
    checks++; if (rv !== 0) begin errors++; $display("FAIL rm_rvalid got %0d exp 0", rv); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rm_ready_after got %b exp 1", ready); end
  endtask

  task automatic test_simultaneous;
    @(negedge clk); core_we = 1; core_rd = 3; core_data = 32'h33; dbg_req = 1; dbg_wr = 0; dbg_addr = 3; #1;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || ready !== 1'b1) begin errors++; $display("FAIL sim_accept got we=%b rd=%0d ready=%b exp 1 3 1", rf_we, rf_rd, ready); end
    @(negedge clk); dbg_req = 0; core_rd = 4; core_data = 32'h44; #1;
    checks++; if (rf_we !== 1'b0 || rf_rs2 !== 5'd3) begin errors++; $display("FAIL sim_dbg got we=%b rs2=%0d exp 0 3", rf_we, rf_rs2); end
    @(negedge clk); core_we = 0; #1;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h33) begin errors++; $display("FAIL sim_read got rvalid=%b rdata=%h exp 1 33", rvalid, rdata); end
    checks++; if (mem[4] !== 32'h0) begin errors++; $display("FAIL sim_x4 got %h exp 0", mem[4]); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_core_write;
    test_dbg_write_read;
    test_back_to_back;
    test_reset_mid_dbg;
    test_simultaneous;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
